// File: rtl/gen_cover_pkg.sv
// Shared constants and helpers for the generated toggle/level cover collectors.
package gen_cover_pkg;

  localparam int MODE_LEVEL    = 0;
  localparam int MODE_TOGGLE   = 1;
  localparam int DEFAULT_IDX_W = 32;

  // Number of cover points one instance owns for a given monitored width.
  function automatic int points(input int width, input int mode);
    return (mode == MODE_TOGGLE) ? 2 * width : width;
  endfunction

endpackage

// File: rtl/cover_evt_fifo.sv
// Synchronous event FIFO with a registered head entry; flush empties it in one cycle.
module cover_evt_fifo #(
  parameter int DEPTH = 8,
  parameter int DW    = 32
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          flush,
  input  logic          push,
  input  logic [DW-1:0] din,
  input  logic          pop,
  output logic [DW-1:0] dout,
  output logic          full,
  output logic          empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("cover_evt_fifo: DEPTH must be a power of two and at least 2");
  end

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] mem_count;
  logic          head_valid;
  logic          do_push;
  logic          do_pop;
  logic          load;

  // Capacity counts the head register too, so DEPTH is the real number of queued events.
  assign full    = (mem_count + CW'(head_valid)) == CW'(DEPTH);
  assign empty   = ~head_valid;
  assign do_pop  = pop & head_valid;
  assign do_push = push & (~full | do_pop);
  assign load    = (mem_count != '0) & (~head_valid | do_pop);

  always_ff @(posedge clock) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      mem_count  <= '0;
      head_valid <= 1'b0;
      dout       <= '0;
    end else if (flush) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      mem_count  <= '0;
      head_valid <= 1'b0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (load) begin
        dout       <= mem[rd_ptr];
        rd_ptr     <= rd_ptr + AW'(1);
        head_valid <= 1'b1;
      end else if (do_pop) begin
        head_valid <= 1'b0;
      end
      mem_count <= mem_count + CW'(do_push) - CW'(load);
    end
  end

endmodule

// File: rtl/gen_toggle_cover_collector.sv
// Sticky level/toggle cover collector: records each point once and streams its global index.
module gen_toggle_cover_collector
  import gen_cover_pkg::*;
#(
  parameter int WIDTH       = 21,
  parameter int MODE        = MODE_TOGGLE,
  parameter int COVER_INDEX = 0,
  parameter int COVER_TOTAL = 38253,
  parameter int IDX_W       = DEFAULT_IDX_W,
  parameter int FIFO_DEPTH  = 8
) (
  input  logic                                   clock,
  input  logic                                   reset,
  input  logic                                   enable,
  input  logic                                   clear,
  input  logic [WIDTH-1:0]                       valid,
  output logic                                   evt_valid,
  input  logic                                   evt_ready,
  output logic [IDX_W-1:0]                       evt_index,
  output logic [points(WIDTH, MODE)-1:0]         hit_map,
  output logic [$clog2(points(WIDTH, MODE)+1)-1:0] hit_count,
  output logic                                   all_hit
);

  localparam int    POINTS  = points(WIDTH, MODE);
  localparam int    HC_W    = $clog2(POINTS + 1);
  localparam int    Q_W     = (POINTS > 1) ? $clog2(POINTS) : 1;
  localparam longint MAX_IDX = longint'(COVER_INDEX) + longint'(POINTS) - 1;

  if (MODE != MODE_LEVEL && MODE != MODE_TOGGLE) begin : g_bad_mode
    $error("gen_toggle_cover_collector: MODE must be 0 (level) or 1 (toggle)");
  end
  if (longint'(COVER_INDEX) + longint'(POINTS) > longint'(COVER_TOTAL)) begin : g_bad_range
    $error("gen_toggle_cover_collector: COVER_INDEX+POINTS exceeds COVER_TOTAL");
  end
  if ((MAX_IDX >> IDX_W) != 0) begin : g_bad_idx_w
    $error("gen_toggle_cover_collector: highest cover index does not fit in IDX_W");
  end

  logic [POINTS-1:0] ev;
  logic [POINTS-1:0] pend;
  logic [POINTS-1:0] capture;
  logic [POINTS-1:0] issue_mask;
  logic [Q_W-1:0]    q;
  logic              have_q;
  logic              push;
  logic              pop;
  logic              fifo_full;
  logic              fifo_empty;
  logic [IDX_W-1:0]  push_data;

  if (MODE == MODE_TOGGLE) begin : g_toggle
    logic [WIDTH-1:0] prev;
    logic             primed;

    // prev and primed survive clear so a clear never manufactures a toggle.
    always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
        prev   <= '0;
        primed <= 1'b0;
      end else begin
        prev   <= valid;
        primed <= 1'b1;
      end
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      assign ev[2*i]   = primed & ~prev[i] & valid[i];
      assign ev[2*i+1] = primed & prev[i] & ~valid[i];
    end
  end else begin : g_level
    assign ev = valid;
  end

  // Excluding pend keeps a capture from ever racing the issue of the same point.
  assign capture = enable ? (ev & ~hit_map & ~pend) : '0;

  always_comb begin
    q      = '0;
    have_q = 1'b0;
    for (int p = POINTS - 1; p >= 0; p--) begin
      if (pend[p]) begin
        q      = Q_W'(p);
        have_q = 1'b1;
      end
    end
  end

  assign pop       = evt_valid & evt_ready;
  assign push      = have_q & (~fifo_full | pop);
  assign push_data = IDX_W'(COVER_INDEX) + IDX_W'(q);

  always_comb begin
    issue_mask = '0;
    if (push) begin
      issue_mask[q] = 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pend      <= '0;
      hit_map   <= '0;
      hit_count <= '0;
    end else if (clear) begin
      pend      <= '0;
      hit_map   <= '0;
      hit_count <= '0;
    end else begin
      pend    <= (pend & ~issue_mask) | capture;
      hit_map <= hit_map | issue_mask;
      if (push) begin
        hit_count <= hit_count + HC_W'(1);
      end
    end
  end

  assign all_hit   = (hit_count == HC_W'(POINTS));
  assign evt_valid = ~fifo_empty;

  cover_evt_fifo #(
    .DEPTH (FIFO_DEPTH),
    .DW    (IDX_W)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .flush (clear),
    .push  (push),
    .din   (push_data),
    .pop   (pop),
    .dout  (evt_index),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

endmodule
